// File: rtl/bus_dma_initiator.sv
// bus_dma_initiator: data-memory bus initiator that copies a block of 32-bit
// words from src to dst, or fills dst with a pattern, under a start/done
// handshake. Request outputs are decoded from registered state only.
module bus_dma_initiator #(
  parameter int LEN_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start_i,
  input  logic              fill_i,
  input  logic [31:0]       src_i,
  input  logic [31:0]       dst_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [31:0]       pattern_i,
  input  logic              abort_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              aborted_o,
  output logic [LEN_W-1:0]  words_done_o,
  input  logic              mem_gnt_i,
  output logic              mem_operation_enable_o,
  output logic [3:0]        mem_write_enable_o,
  output logic [31:0]       mem_address_o,
  output logic [31:0]       mem_data_o,
  input  logic [31:0]       mem_data_i
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_RWAIT = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             r_state, w_state;
  logic [31:0]        r_src, w_src;
  logic [31:0]        r_dst, w_dst;
  logic [31:0]        r_pattern, w_pattern;
  logic [31:0]        r_buf, w_buf;
  logic [LEN_W-1:0]   r_len, w_len;
  logic [LEN_W-1:0]   r_words, w_words;
  logic               r_fill, w_fill;
  logic               r_err, w_err;
  logic               r_aborted, w_aborted;
  logic [LEN_W-1:0]   w_words_inc;

  localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  assign w_words_inc = r_words + LEN_ONE;

  // State and datapath registers; everything clears on reset so an
  // in-flight request is dropped immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_src     <= '0;
      r_dst     <= '0;
      r_pattern <= '0;
      r_buf     <= '0;
      r_len     <= '0;
      r_words   <= '0;
      r_fill    <= 1'b0;
      r_err     <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_src     <= w_src;
      r_dst     <= w_dst;
      r_pattern <= w_pattern;
      r_buf     <= w_buf;
      r_len     <= w_len;
      r_words   <= w_words;
      r_fill    <= w_fill;
      r_err     <= w_err;
      r_aborted <= w_aborted;
    end
  end

  // Next-state and next-datapath logic. Abort is checked before normal
  // completion so a granted final write with abort still reports aborted.
  always_comb begin
    w_state   = r_state;
    w_src     = r_src;
    w_dst     = r_dst;
    w_pattern = r_pattern;
    w_buf     = r_buf;
    w_len     = r_len;
    w_words   = r_words;
    w_fill    = r_fill;
    w_err     = r_err;
    w_aborted = r_aborted;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_src     = src_i;
          w_dst     = dst_i;
          w_len     = len_i;
          w_fill    = fill_i;
          w_pattern = pattern_i;
          w_words   = '0;
          w_err     = 1'b0;
          w_aborted = 1'b0;
          // src alignment only matters when we actually read from it
          if ((dst_i[1:0] != 2'b00) || (!fill_i && (src_i[1:0] != 2'b00))) begin
            w_err   = 1'b1;
            w_state = S_DONE;
          end else if (len_i == '0) begin
            w_state = S_DONE;
          end else if (fill_i) begin
            w_state = S_WRITE;
          end else begin
            w_state = S_READ;
          end
        end
      end
      S_READ: begin
        if (mem_gnt_i) begin
          if (abort_i) begin
            w_aborted = 1'b1;
            w_state   = S_DONE;
          end else begin
            w_state   = S_RWAIT;
          end
        end else if (abort_i) begin
          w_aborted = 1'b1;
          w_state   = S_DONE;
        end
      end
      S_RWAIT: begin
        if (abort_i) begin
          w_aborted = 1'b1;
          w_state   = S_DONE;
        end else begin
          w_buf   = mem_data_i;
          w_state = S_WRITE;
        end
      end
      S_WRITE: begin
        if (mem_gnt_i) begin
          w_words = w_words_inc;
          w_dst   = r_dst + 32'd4;
          if (!r_fill) begin
            w_src = r_src + 32'd4;
          end
          if (abort_i) begin
            w_aborted = 1'b1;
            w_state   = S_DONE;
          end else if (w_words_inc == r_len) begin
            w_state = S_DONE;
          end else if (r_fill) begin
            w_state = S_WRITE;
          end else begin
            w_state = S_READ;
          end
        end else if (abort_i) begin
          w_aborted = 1'b1;
          w_state   = S_DONE;
        end
      end
      S_DONE: begin
        w_state = S_IDLE;
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  // Output decode from registered state; address/data are zero when idle.
  always_comb begin
    busy_o                 = (r_state != S_IDLE);
    done_o                 = (r_state == S_DONE);
    err_o                  = r_err;
    aborted_o              = r_aborted;
    words_done_o           = r_words;
    mem_operation_enable_o = 1'b0;
    mem_write_enable_o     = 4'h0;
    mem_address_o          = 32'h0;
    mem_data_o             = 32'h0;
    if (r_state == S_READ) begin
      mem_operation_enable_o = 1'b1;
      mem_address_o          = r_src;
    end else if (r_state == S_WRITE) begin
      mem_operation_enable_o = 1'b1;
      mem_write_enable_o     = 4'hF;
      mem_address_o          = r_dst;
      mem_data_o             = r_fill ? r_pattern : r_buf;
    end
  end

endmodule

// File: tb/tb_bus_dma_initiator.sv
// Testbench for bus_dma_initiator: a word-addressed memory responder with a
// controllable grant, scenario tasks, and a transfer-level reference model.
module tb_bus_dma_initiator;
  localparam int LEN_W = 16;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start_i = 1'b0;
  logic              fill_i = 1'b0;
  logic [31:0]       src_i = '0;
  logic [31:0]       dst_i = '0;
  logic [LEN_W-1:0]  len_i = '0;
  logic [31:0]       pattern_i = '0;
  logic              abort_i = 1'b0;
  logic              busy_o, done_o, err_o, aborted_o;
  logic [LEN_W-1:0]  words_done_o;
  logic              mem_gnt_i = 1'b1;
  logic              mem_operation_enable_o;
  logic [3:0]        mem_write_enable_o;
  logic [31:0]       mem_address_o, mem_data_o;
  logic [31:0]       mem_data_i = '0;

  bus_dma_initiator #(.LEN_W(LEN_W)) dut (
    .clk(clk), .reset_n(reset_n), .start_i(start_i), .fill_i(fill_i),
    .src_i(src_i), .dst_i(dst_i), .len_i(len_i), .pattern_i(pattern_i),
    .abort_i(abort_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .aborted_o(aborted_o), .words_done_o(words_done_o), .mem_gnt_i(mem_gnt_i),
    .mem_operation_enable_o(mem_operation_enable_o),
    .mem_write_enable_o(mem_write_enable_o), .mem_address_o(mem_address_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // memory and bus observation
  logic [31:0] mem [logic [31:0]];
  logic [31:0] wq_a[$];
  logic [31:0] wq_d[$];
  bit          ops[$];
  int          stalls = 0;
  int          nreq = 0;
  int          stab_viol = 0;
  logic        busy_before = 1'b0;

  // grant control
  bit gnt_rand = 0;
  int rstall = 0;
  int wstall = 0;

  // stability tracking across stalled cycles
  bit          prev_stall = 0;
  bit          prev_abort = 0;
  logic [31:0] prev_addr = '0, prev_data = '0;
  logic [3:0]  prev_we = '0;

  always @(negedge clk) begin
    if (gnt_rand) mem_gnt_i = ($urandom_range(0, 3) != 0);
    else if (mem_operation_enable_o && mem_write_enable_o == 4'h0 && rstall > 0) begin
      mem_gnt_i = 1'b0; rstall--;
    end else if (mem_operation_enable_o && mem_write_enable_o == 4'hF && wstall > 0) begin
      mem_gnt_i = 1'b0; wstall--;
    end else mem_gnt_i = 1'b1;
  end

  always @(posedge clk) begin
    if (reset_n && prev_stall && !prev_abort) begin
      if (!(mem_operation_enable_o && mem_address_o == prev_addr &&
            mem_write_enable_o == prev_we && mem_data_o == prev_data))
        stab_viol++;
    end
    prev_stall = reset_n && mem_operation_enable_o && !mem_gnt_i;
    prev_abort = abort_i;
    prev_addr  = mem_address_o;
    prev_data  = mem_data_o;
    prev_we    = mem_write_enable_o;
    mem_data_i <= 32'hBAD0BAD0;
    if (reset_n && mem_operation_enable_o) begin
      if (mem_gnt_i) begin
        nreq++;
        if (mem_write_enable_o == 4'hF) begin
          mem[mem_address_o] = mem_data_o;
          wq_a.push_back(mem_address_o);
          wq_d.push_back(mem_data_o);
          ops.push_back(1'b1);
        end else begin
          mem_data_i <= mem.exists(mem_address_o) ? mem[mem_address_o] : 32'h0;
          ops.push_back(1'b0);
        end
      end else begin
        stalls++;
      end
    end
  end

  // Issue one command, scramble the command inputs afterwards, and return the
  // cycle (counted from the start edge) at which done_o was seen.
  task automatic run_cmd(input logic f, input logic [31:0] s, input logic [31:0] d,
                         input logic [LEN_W-1:0] l, input logic [31:0] p,
                         input int abort_cyc, output int dc);
    wq_a.delete(); wq_d.delete(); ops.delete();
    stalls = 0; nreq = 0; stab_viol = 0;
    @(negedge clk);
    busy_before = busy_o;
    fill_i = f; src_i = s; dst_i = d; len_i = l; pattern_i = p; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    fill_i = 1'($urandom_range(0, 1)); src_i = $urandom; dst_i = $urandom;
    len_i = LEN_W'($urandom); pattern_i = $urandom;
    dc = -1;
    for (int k = 1; k <= 600; k++) begin
      if (done_o) begin dc = k; break; end
      abort_i = (k == abort_cyc);
      @(negedge clk);
    end
    abort_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy_o, done_o, err_o, aborted_o, mem_operation_enable_o} !== 5'b0 ||
        mem_write_enable_o !== 4'h0 || mem_address_o !== 32'h0 ||
        mem_data_o !== 32'h0 || words_done_o !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b err=%b ab=%b en=%b we=%h addr=%h data=%h wd=%0d required all zero",
               busy_o, done_o, err_o, aborted_o, mem_operation_enable_o,
               mem_write_enable_o, mem_address_o, mem_data_o, words_done_o);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_copy();
    int dc;
    logic [31:0] exp_d [4];
    exp_d[0] = 32'h11111111; exp_d[1] = 32'h22222222;
    exp_d[2] = 32'h33333333; exp_d[3] = 32'h44444444;
    for (int i = 0; i < 4; i++) begin
      mem[32'h100 + 32'(4*i)] = exp_d[i];
      mem[32'h200 + 32'(4*i)] = 32'h0;
    end
    run_cmd(1'b0, 32'h100, 32'h200, 16'd4, 32'h0, 0, dc);
    checks++;
    if (dc !== 13) begin errors++; $display("FAIL copy_done_cycle: got %0d required 13", dc); end
    checks++;
    if (words_done_o !== 16'd4) begin errors++; $display("FAIL copy_words: got %0d required 4", words_done_o); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[32'h200 + 32'(4*i)] !== exp_d[i]) begin
        errors++;
        $display("FAIL copy_data[%0d]: got %h required %h", i, mem[32'h200 + 32'(4*i)], exp_d[i]);
      end
    end
    begin
      bit alt_ok = (ops.size() == 8);
      for (int i = 0; i < ops.size(); i++) if (ops[i] != bit'(i % 2)) alt_ok = 0;
      checks++;
      if (!alt_ok) begin errors++; $display("FAIL copy_interleave: %0d ops, not read/write alternating (required 8 alternating)", ops.size()); end
    end
  endtask

  task automatic test_fill();
    int dc;
    run_cmd(1'b1, 32'h3, 32'h400, 16'd3, 32'hDEADBEEF, 0, dc);
    checks++;
    if (dc !== 4) begin errors++; $display("FAIL fill_done_cycle: got %0d required 4", dc); end
    checks++;
    if (wq_a.size() != 3 || err_o !== 1'b0) begin
      errors++; $display("FAIL fill_count: writes %0d err %b required 3 writes err 0", wq_a.size(), err_o);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (wq_a[i] !== 32'h400 + 32'(4*i) || wq_d[i] !== 32'hDEADBEEF) begin
          errors++;
          $display("FAIL fill_write[%0d]: got %h=%h required %h=deadbeef", i, wq_a[i], wq_d[i], 32'h400 + 32'(4*i));
        end
      end
    end
  endtask

  task automatic test_stall();
    int dc;
    mem[32'h900] = 32'hCAFEF00D;
    rstall = 5; wstall = 2;
    run_cmd(1'b0, 32'h900, 32'hA00, 16'd1, 32'h0, 0, dc);
    rstall = 0; wstall = 0;
    checks++;
    if (dc !== 11) begin errors++; $display("FAIL stall_done_cycle: got %0d required 11", dc); end
    checks++;
    if (stab_viol != 0) begin errors++; $display("FAIL stall_stability: %0d unstable cycles required 0", stab_viol); end
    checks++;
    if (wq_a.size() != 1 || mem[32'hA00] !== 32'hCAFEF00D) begin
      errors++; $display("FAIL stall_write: writes %0d data %h required 1 write cafef00d", wq_a.size(), mem[32'hA00]);
    end
  endtask

  task automatic test_errors();
    int dc;
    run_cmd(1'b0, 32'h102, 32'h200, 16'd4, 32'h0, 0, dc);
    checks++;
    if (dc !== 1 || err_o !== 1'b1 || nreq != 0 || stalls != 0) begin
      errors++; $display("FAIL err_misaligned: dc %0d err %b reqs %0d required dc 1 err 1 reqs 0", dc, err_o, nreq + stalls);
    end
    run_cmd(1'b1, 32'h0, 32'h201, 16'd2, 32'h5, 0, dc);
    checks++;
    if (dc !== 1 || err_o !== 1'b1 || nreq + stalls != 0) begin
      errors++; $display("FAIL err_dst_misaligned: dc %0d err %b reqs %0d required dc 1 err 1 reqs 0", dc, err_o, nreq + stalls);
    end
    run_cmd(1'b0, 32'h100, 32'h200, 16'd0, 32'h0, 0, dc);
    checks++;
    if (dc !== 1 || err_o !== 1'b0 || nreq + stalls != 0 || words_done_o !== '0) begin
      errors++; $display("FAIL len_zero: dc %0d err %b reqs %0d wd %0d required dc 1 err 0 reqs 0 wd 0", dc, err_o, nreq + stalls, words_done_o);
    end
    run_cmd(1'b1, 32'h0, 32'hFFFFFFFC, 16'd2, 32'h5A5A5A5A, 0, dc);
    checks++;
    if (dc !== 3 || wq_a.size() != 2) begin
      errors++; $display("FAIL wrap_count: dc %0d writes %0d required dc 3 writes 2", dc, wq_a.size());
    end else begin
      checks++;
      if (wq_a[0] !== 32'hFFFFFFFC || wq_a[1] !== 32'h0) begin
        errors++; $display("FAIL wrap_addr: got %h,%h required fffffffc,00000000", wq_a[0], wq_a[1]);
      end
    end
  endtask

  task automatic test_abort();
    int dc;
    for (int i = 0; i < 8; i++) begin
      mem[32'h1000 + 32'(4*i)] = 32'hA0000000 + 32'(i);
      mem[32'h2000 + 32'(4*i)] = 32'h0;
    end
    // with grant always high, RWAIT of word n falls in cycle 3n-1
    run_cmd(1'b0, 32'h1000, 32'h2000, 16'd8, 32'h0, 8, dc);
    checks++;
    if (dc !== 9 || words_done_o !== 16'd2 || aborted_o !== 1'b1) begin
      errors++; $display("FAIL abort_rwait: dc %0d wd %0d ab %b required dc 9 wd 2 ab 1", dc, words_done_o, aborted_o);
    end
    checks++;
    if (wq_a.size() != 2 || mem[32'h2008] !== 32'h0) begin
      errors++; $display("FAIL abort_no_write: writes %0d word3 %h required 2 writes word3 0", wq_a.size(), mem[32'h2008]);
    end
    // abort on the final granted write: completes, still reports abort
    run_cmd(1'b1, 32'h0, 32'h3000, 16'd2, 32'h77, 2, dc);
    checks++;
    if (dc !== 3 || words_done_o !== 16'd2 || aborted_o !== 1'b1 || wq_a.size() != 2) begin
      errors++; $display("FAIL abort_final_write: dc %0d wd %0d ab %b writes %0d required 3 2 1 2", dc, words_done_o, aborted_o, wq_a.size());
    end
    // abort while the write is not granted: request is dropped
    mem[32'h3100] = 32'h12345678;
    wstall = 5;
    run_cmd(1'b0, 32'h3100, 32'h3200, 16'd1, 32'h0, 3, dc);
    wstall = 0;
    checks++;
    if (dc !== 4 || words_done_o !== '0 || aborted_o !== 1'b1 || wq_a.size() != 0) begin
      errors++; $display("FAIL abort_stalled_write: dc %0d wd %0d ab %b writes %0d required 4 0 1 0", dc, words_done_o, aborted_o, wq_a.size());
    end
    run_cmd(1'b1, 32'h0, 32'h3300, 16'd1, 32'h1, 0, dc);
    checks++;
    if (aborted_o !== 1'b0 || dc !== 2) begin
      errors++; $display("FAIL abort_cleared: ab %b dc %0d required ab 0 dc 2", aborted_o, dc);
    end
  endtask

  task automatic test_back_to_back();
    int dc;
    run_cmd(1'b1, 32'h0, 32'h3400, 16'd2, 32'hAB, 0, dc);
    run_cmd(1'b1, 32'h0, 32'h3500, 16'd3, 32'hCD, 0, dc);
    checks++;
    if (busy_before !== 1'b0 || dc !== 4 || mem[32'h3508] !== 32'hCD) begin
      errors++; $display("FAIL back_to_back: busy_before %b dc %0d last %h required 0 4 000000cd", busy_before, dc, mem[32'h3508]);
    end
  endtask

  task automatic test_random();
    int dc;
    gnt_rand = 1;
    for (int t = 0; t < 8; t++) begin
      logic              f = 1'($urandom_range(0, 1));
      logic [31:0]       s = 32'h4000 + 32'($urandom_range(0, 63) * 4);
      logic [31:0]       d = 32'h8000 + 32'($urandom_range(0, 63) * 4);
      logic [LEN_W-1:0]  l = LEN_W'($urandom_range(1, 6));
      logic [31:0]       p = $urandom;
      logic [31:0]       exp_v [$];
      int                base;
      bit                ok;
      for (int i = 0; i < int'(l); i++) begin
        logic [31:0] v = $urandom;
        mem[s + 32'(4*i)] = v;
        exp_v.push_back(f ? p : v);
      end
      run_cmd(f, s, d, l, p, 0, dc);
      base = f ? int'(l) + 1 : 3 * int'(l) + 1;
      checks++;
      if (dc !== base + stalls || words_done_o !== l) begin
        errors++; $display("FAIL rand%0d_timing: dc %0d wd %0d required dc %0d wd %0d", t, dc, words_done_o, base + stalls, l);
      end
      ok = (wq_a.size() == int'(l)) && (stab_viol == 0);
      for (int i = 0; i < int'(l) && ok; i++)
        if (wq_a[i] !== d + 32'(4*i) || wq_d[i] !== exp_v[i]) ok = 0;
      checks++;
      if (!ok) begin
        errors++; $display("FAIL rand%0d_data: writes %0d unstable %0d required %0d in-order writes of expected data", t, wq_a.size(), stab_viol, l);
      end
    end
    gnt_rand = 0;
  endtask

  task automatic test_reset_mid();
    int dc;
    @(negedge clk);
    fill_i = 1'b1; dst_i = 32'h600; len_i = 16'd10; pattern_i = 32'h99; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (mem_operation_enable_o !== 1'b1) begin errors++; $display("FAIL reset_mid_pre: en %b required 1", mem_operation_enable_o); end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({busy_o, done_o, err_o, aborted_o, mem_operation_enable_o} !== 5'b0 ||
        mem_write_enable_o !== 4'h0 || mem_address_o !== 32'h0 ||
        mem_data_o !== 32'h0 || words_done_o !== '0) begin
      errors++;
      $display("FAIL reset_mid_async: busy=%b en=%b we=%h addr=%h data=%h wd=%0d required all zero",
               busy_o, mem_operation_enable_o, mem_write_enable_o, mem_address_o, mem_data_o, words_done_o);
    end
    @(negedge clk);
    reset_n = 1'b1;
    mem[32'h4800] = 32'h0BADCAFE;
    run_cmd(1'b0, 32'h4800, 32'h4900, 16'd1, 32'h0, 0, dc);
    checks++;
    if (dc !== 4 || mem[32'h4900] !== 32'h0BADCAFE || words_done_o !== 16'd1) begin
      errors++; $display("FAIL reset_mid_recover: dc %0d data %h wd %0d required 4 0badcafe 1", dc, mem[32'h4900], words_done_o);
    end
  endtask

  initial begin
    test_reset();
    test_copy();
    test_fill();
    test_stall();
    test_errors();
    test_abort();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
